// File: rtl/alu_mem_pkg.sv
// Shared types and widths for the arbitrated ALU with result memory.
package alu_mem_pkg;

    localparam int unsigned OPND_W    = 2;
    localparam int unsigned RES_W     = 4;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
    localparam int unsigned DZ_CNT_W  = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              id;
    } req_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 2-bit ALU: add/sub/mul/div with carry, borrow and divide-by-zero flag.
module alu_core
    import alu_mem_pkg::*;
#(
    parameter logic [RES_W-1:0] DZ_VAL = 4'h0
) (
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  op_e               op,
    output logic [RES_W-1:0]  y,
    output logic              c,
    output logic              dz
);

    logic [RES_W:0] a_ext;
    logic [RES_W:0] b_ext;
    logic [RES_W:0] wide;

    always_comb begin
        a_ext = (RES_W+1)'(a);
        b_ext = (RES_W+1)'(b);
        wide  = '0;
        dz    = 1'b0;
        case (op)
            OP_ADD: wide = a_ext + b_ext;
            // Wrap-around of the 5-bit difference yields borrow in the top bit
            OP_SUB: wide = a_ext - b_ext;
            OP_MUL: wide = a_ext * b_ext;
            OP_DIV: begin
                if (b == '0) begin
                    wide = {1'b1, DZ_VAL};
                    dz   = 1'b1;
                end else begin
                    wide = a_ext / b_ext;
                end
            end
            default: wide = '0;
        endcase
        y = wide[RES_W-1:0];
        c = wide[RES_W];
    end

endmodule

// File: rtl/alu_mem_arbiter.sv
// Two-requester round-robin front end to a one-op-at-a-time ALU, with a 4x4
// result memory and a saturating divide-by-zero counter.
module alu_mem_arbiter
    import alu_mem_pkg::*;
#(
    parameter logic [RES_W-1:0] DZ_VAL = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OPND_W-1:0]   req0_a,
    input  logic [OPND_W-1:0]   req0_b,
    input  logic [1:0]          req0_op,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic                req0_we,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OPND_W-1:0]   req1_a,
    input  logic [OPND_W-1:0]   req1_b,
    input  logic [1:0]          req1_op,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic                req1_we,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [RES_W-1:0]    rsp_y,
    output logic                rsp_c,
    input  logic                rsp_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [RES_W-1:0]    rd_data,
    output logic [DZ_CNT_W-1:0] dz_count
);

    state_e              state_q;
    logic                last_q;
    req_t                cur_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [RES_W-1:0]    rsp_y_q;
    logic                rsp_c_q;
    logic [DZ_CNT_W-1:0] dz_q;
    logic [RES_W-1:0]    mem_q [MEM_DEPTH];

    logic                grant_d;
    logic                accept;
    req_t                sel_req;

    logic [RES_W-1:0]    alu_y;
    logic                alu_c;
    logic                alu_dz;

    // Under contention the requester not granted last time wins
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_d = ~last_q;
        end else begin
            grant_d = req1_valid;
        end
        accept     = (state_q == ST_IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = accept && !grant_d;
        req1_ready = accept && grant_d;

        sel_req = '0;
        if (grant_d) begin
            sel_req.a    = req1_a;
            sel_req.b    = req1_b;
            sel_req.op   = op_e'(req1_op);
            sel_req.addr = req1_addr;
            sel_req.we   = req1_we;
            sel_req.id   = 1'b1;
        end else begin
            sel_req.a    = req0_a;
            sel_req.b    = req0_b;
            sel_req.op   = op_e'(req0_op);
            sel_req.addr = req0_addr;
            sel_req.we   = req0_we;
            sel_req.id   = 1'b0;
        end
    end

    alu_core #(
        .DZ_VAL (DZ_VAL)
    ) u_alu_core (
        .a  (cur_q.a),
        .b  (cur_q.b),
        .op (cur_q.op),
        .y  (alu_y),
        .c  (alu_c),
        .dz (alu_dz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            cur_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_c_q     <= 1'b0;
            dz_q        <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cur_q   <= sel_req;
                        last_q  <= grant_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y_q     <= alu_y;
                    rsp_c_q     <= alu_c;
                    rsp_id_q    <= cur_q.id;
                    rsp_valid_q <= 1'b1;
                    if (cur_q.we) begin
                        mem_q[cur_q.addr] <= alu_y;
                    end
                    if (alu_dz && (dz_q != '1)) begin
                        dz_q <= dz_q + 1'b1;
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_c     = rsp_c_q;
    assign rd_data   = mem_q[rd_addr];
    assign dz_count  = dz_q;

endmodule

// File: tb/tb_alu_mem_arbiter.sv
// Scoreboard bench for alu_mem_arbiter: arithmetic reference model, directed and random traffic.
module tb_alu_mem_arbiter;

    localparam int DZ = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       rv    [2];
    logic [1:0] ra    [2];
    logic [1:0] rb    [2];
    logic [1:0] rop   [2];
    logic [1:0] raddr [2];
    logic       rwe   [2];
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_c, rsp_ready;
    logic [3:0] rsp_y, rd_data, dz_count;
    logic [1:0] rd_addr;

    alu_mem_arbiter #(
        .DZ_VAL (4'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (rv[0]),
        .req0_ready (req0_ready),
        .req0_a     (ra[0]),
        .req0_b     (rb[0]),
        .req0_op    (rop[0]),
        .req0_addr  (raddr[0]),
        .req0_we    (rwe[0]),
        .req1_valid (rv[1]),
        .req1_ready (req1_ready),
        .req1_a     (ra[1]),
        .req1_b     (rb[1]),
        .req1_op    (rop[1]),
        .req1_addr  (raddr[1]),
        .req1_we    (rwe[1]),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_c      (rsp_c),
        .rsp_ready  (rsp_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dz_count   (dz_count)
    );

    typedef struct {
        bit id;
        int y;
        int c;
        int acc;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bit   m_last;
    int   m_mem [4];
    int   m_dz;
    int   m_old;
    int   m_exec_addr;
    bit   m_grant;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference arithmetic straight from the operation rules
    function automatic void ref_alu(input int a, input int b, input int op, output int y, output int c);
        c = 0;
        y = 0;
        case (op)
            0: y = a + b;
            1: begin
                if (a >= b) y = a - b;
                else begin
                    y = 16 + a - b;
                    c = 1;
                end
            end
            2: y = a * b;
            default: begin
                if (b == 0) begin
                    y = DZ;
                    c = 1;
                end else y = a / b;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_last = 1'b1;
        m_dz   = 0;
        for (int i = 0; i < 4; i++) m_mem[i] = 0;
        sb.delete();
    endtask

    task automatic set_req(input int n, input bit v, input int a, input int b, input int op,
                           input int addr, input bit we);
        rv[n]    = v;
        ra[n]    = 2'(a);
        rb[n]    = 2'(b);
        rop[n]   = 2'(op);
        raddr[n] = 2'(addr);
        rwe[n]   = we;
    endtask

    task automatic rand_req(input int n);
        set_req(n, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_accept(output int waited);
        bit got;
        got = 0;
        waited = 0;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            if (req0_ready || req1_ready) begin
                bit   g;
                int   y, c;
                exp_t e;
                g = (rv[0] && rv[1]) ? !m_last : rv[1];
                chk("grant", {6'd0, req1_ready, req0_ready}, g ? 8'd2 : 8'd1);
                ref_alu(int'(ra[g]), int'(rb[g]), int'(rop[g]), y, c);
                e.id  = g;
                e.y   = y;
                e.c   = c;
                e.acc = cyc;
                sb.push_back(e);
                m_exec_addr = int'(raddr[g]);
                m_old       = m_mem[m_exec_addr];
                if (rwe[g]) m_mem[m_exec_addr] = y;
                if (rop[g] == 2'd3 && rb[g] == 2'd0 && m_dz < 15) m_dz++;
                m_last  = g;
                m_grant = g;
                got     = 1;
            end
        end
        if (!got) timeout("accept");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int stall);
        bit got;
        got       = 0;
        rd_addr   = 2'(m_exec_addr);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("exec_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        chk("exec_rd_old", {4'd0, rd_data}, 8'(m_old));
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        if (!got) timeout("response");
        else begin
            chk("dz_count", {4'd0, dz_count}, 8'(m_dz));
            for (int i = 0; i < 4; i++) begin
                rd_addr = 2'(i);
                #1;
                chk("mem_rd", {4'd0, rd_data}, 8'(m_mem[i]));
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // Monitor: compares each presented response against the scoreboard head
    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
                continue;
            end
            if (rsp_valid) begin
                chk("resp_ready_low", {6'd0, req1_ready, req0_ready}, 8'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=valid required=none y=%0h", rsp_y);
                end else begin
                    exp_t e;
                    e = sb[0];
                    if (!prev) chk("latency", 8'(cyc - e.acc), 8'd2);
                    chk("rsp_id", {7'd0, rsp_id}, {7'd0, e.id});
                    chk("rsp_y", {4'd0, rsp_y}, 8'(e.y));
                    chk("rsp_c", {7'd0, rsp_c}, 8'(e.c));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            prev = rsp_valid && !rsp_ready;
        end
    end

    initial begin
        int w;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        rd_addr   = 2'd0;
        for (int n = 0; n < 2; n++) set_req(n, 1'b0, 0, 0, 0, 0, 1'b0);
        model_reset();

        @(posedge clk);
        #1;
        set_req(0, 1'b1, 3, 3, 0, 2, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready0", {7'd0, req0_ready}, 8'd0);
        chk("rst_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_y", {4'd0, rsp_y}, 8'd0);
        chk("rst_c", {7'd0, rsp_c}, 8'd0);
        chk("rst_id", {7'd0, rsp_id}, 8'd0);
        chk("rst_dz", {4'd0, dz_count}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk("rst_mem", {4'd0, rd_data}, 8'd0);
        end
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        rst   = 1'b0;
        model_reset();

        // Single add writing address 2, then a borrowing subtract without write
        set_req(0, 1'b1, 3, 3, 0, 2, 1'b1);
        wait_accept(w);
        rv[0] = 1'b0;
        wait_resp(0);
        set_req(1, 1'b1, 0, 1, 1, 3, 1'b0);
        wait_accept(w);
        rv[1] = 1'b0;
        wait_resp(0);

        // Continuous contention
        rand_req(0);
        rand_req(1);
        repeat (4) begin
            wait_accept(w);
            rand_req(int'(m_grant));
            wait_resp($urandom_range(0, 2));
        end
        rv[0] = 1'b0;
        rv[1] = 1'b0;

        // Divide by zero saturation, then a normal divide
        repeat (17) begin
            set_req(0, 1'b1, 2, 0, 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            wait_accept(w);
            rv[0] = 1'b0;
            wait_resp(0);
        end
        set_req(0, 1'b1, 3, 2, 3, 0, 1'b1);
        wait_accept(w);
        rv[0] = 1'b0;
        wait_resp(0);

        // Backpressure with a competing request pending through EXEC and RESP
        set_req(1, 1'b1, 3, 3, 2, 0, 1'b1);
        wait_accept(w);
        rv[1] = 1'b0;
        set_req(0, 1'b1, 1, 2, 0, 3, 1'b1);
        wait_resp(5);
        wait_accept(w);
        rv[0] = 1'b0;
        wait_resp(0);

        // Reset while a write to address 1 is executing
        set_req(0, 1'b1, 3, 2, 0, 1, 1'b1);
        wait_accept(w);
        rv[0] = 1'b0;
        wait_resp(0);
        set_req(0, 1'b1, 3, 3, 0, 1, 1'b1);
        wait_accept(w);
        rv[0]   = 1'b0;
        rst     = 1'b1;
        rd_addr = 2'd1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_req(1, 1'b1, 1, 1, 0, 0, 1'b0);
        #2;
        chk("rstmid_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rstmid_mem1", {4'd0, rd_data}, 8'd0);
        chk("rstmid_dz", {4'd0, dz_count}, 8'd0);
        wait_accept(w);
        chk("idle_after_rst", 8'(w), 8'd1);
        rv[1] = 1'b0;
        wait_resp(0);

        // Random traffic, including withdrawn requests
        repeat (150) begin
            int p;
            p = $urandom_range(0, 2);
            if (p != 1) rand_req(0);
            if (p != 0) rand_req(1);
            wait_accept(w);
            rv[int'(m_grant)] = 1'b0;
            if ($urandom_range(0, 1) == 1) rv[int'(!m_grant)] = 1'b0;
            wait_resp($urandom_range(0, 3));
        end
        rv[0] = 1'b0;
        rv[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mem_arbiter.md
ALU_MEM_ARBITER -- requirements
Module: alu_mem_arbiter

Interface
REQ-001 Parameter: DZ_VAL, 4'h0, y value returned for divide-by-zero.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  out  1  (N=0,1) requester N's operation accepted this cycle when high with reqN_valid.
REQ-006 reqN_a, reqN_b  in  2 each  operands A, B.
REQ-007 reqN_op  in  2  op: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 reqN_addr  in  2  result-memory write address.
REQ-009 reqN_we  in  1  store result to memory when high.
REQ-010 rsp_valid  out  1  result available; rsp_id  out  1  owning requester; rsp_y  out  4  result; rsp_c  out  1  carry/borrow/error.
REQ-011 rsp_ready  in  1  consumer accepts response when high with rsp_valid.
REQ-012 rd_addr  in  2, rd_data  out  4  combinational read of result memory.
REQ-013 dz_count  out  4  saturating count of divide-by-zero operations.

Function
REQ-014 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert only its reqN_ready combinationally, latch a/b/op/addr/we/id, go EXEC; reqN_ready SHALL be 0 in EXEC and RESP.
REQ-016 Arbitration round-robin: single valid requester wins; both valid -> requester not granted last time wins; last-grant register resets to 1 so req0 wins first contention.
REQ-017 EXEC (one cycle): compute result, register rsp_y/rsp_c/rsp_id, write memory[addr]=y at end of cycle if we, go RESP.
REQ-018 RESP: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready; then go IDLE next cycle with rsp_valid=0.
REQ-019 Latency: accept at cycle T -> rsp_valid high from T+2; next accept no earlier than the cycle after response handshake.
REQ-020 Add: {c,y} = 5-bit A+B (c always 0, y in 0..6).
REQ-021 Sub: {c,y} = 5-bit two's-complement A-B (A<B gives c=1, y=upper nibble ones, e.g. 0-1 -> c=1, y=4'hF).
REQ-022 Mul: y = A*B (0..9), c=0.
REQ-023 Div: B!=0 -> y=A/B truncated, c=0; B==0 -> y=DZ_VAL, c=1, dz_count increments, saturating at 15.
REQ-024 Memory 4x4 bits; rd_data reflects pre-edge contents when rd_addr equals a write address in the write cycle (new value visible next cycle).
REQ-025 Requester deasserting valid before ready: no transaction; arbiter takes no action.

Reset
REQ-026 rst high dominates all inputs: state IDLE, rsp_valid=0, rsp_y=0, rsp_c=0, rsp_id=0, reqN_ready=0 during reset cycle, dz_count=0, all memory entries=0, last-grant=1.
REQ-027 rst asserted in EXEC or RESP discards the in-flight operation; no memory write and no dz_count update occurs in that cycle.

Structure
REQ-028 Shared package alu_mem_pkg holds op encodings, FSM state enum, operand/result/address width constants.
REQ-029 Combinational datapath in sub-module alu_core (inputs a, b, op; outputs y, c, dz); arbiter, FSM, memory, counter in alu_mem_arbiter.

Verification
REQ-030 Single add: req0 a=3 b=3 op=00 addr=2 we=1, rsp_ready=1 -> rsp_valid at T+2, rsp_y=6, rsp_c=0, rsp_id=0; next cycle rd_addr=2 -> rd_data=6.
REQ-031 Sub borrow: req1 a=0 b=1 op=01 we=0 -> rsp_y=4'hF, rsp_c=1, rsp_id=1; memory unchanged.
REQ-032 Contention: both valid continuously, 4 ops -> grants ordered 0,1,0,1; each reqN_ready one-cycle pulse.
REQ-033 Divide by zero: 17 x (a=2 b=0 op=11) -> each rsp_y=0, rsp_c=1; dz_count reaches 15 and holds; a=3 b=2 div -> y=1, c=0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles with mul a=3 b=3 -> rsp_valid held, rsp_y=9 stable, both reqN_ready=0 until handshake.
REQ-035 Reset mid-op: rst in EXEC of write to addr 1 -> rsp_valid=0, rd_data(addr 1)=0, state IDLE next cycle.
